// File: rtl/vector_alu_pipe.sv
// vector_alu_pipe: pipelined lane-parallel vector ALU with valid/ready backpressure, flush and lane masks.
// Define VALU_SAT_EN for unsigned saturating ADD/SUB and the sat_flag output.
module vector_alu_pipe #(
    parameter int LANES  = 16,
    parameter int LANE_W = 8,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4:0]              in_op,
    input  logic [LANES*LANE_W-1:0] in_srcA,
    input  logic [LANES*LANE_W-1:0] in_srcB,
    input  logic [LANES-1:0]        in_mask,
    input  logic [TAG_W-1:0]        in_rd,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*LANE_W-1:0] out_result,
    output logic [TAG_W-1:0]        out_rd,
    output logic [LANES-1:0]        out_mask,
    output logic                    out_illegal,
`ifdef VALU_SAT_EN
    output logic                    sat_flag,
`endif
    output logic                    busy
);
    localparam int VW = LANES * LANE_W;
    localparam int SH = $clog2(LANE_W);

    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("vector_alu_pipe: STAGES must be in 1..4");
    end

    typedef struct packed {
        logic             v;
        logic [VW-1:0]    res;
        logic [TAG_W-1:0] rd;
        logic [LANES-1:0] mask;
        logic             ill;
`ifdef VALU_SAT_EN
        logic             sat;
`endif
    } stage_t;

    stage_t            st [STAGES];
    stage_t            nxt;
    logic [STAGES-1:0] v;
    logic [STAGES-1:0] rdy;
    logic              acc;

    function automatic logic [LANE_W-1:0] lane_alu(input logic [4:0] op, input logic [LANE_W-1:0] a, input logic [LANE_W-1:0] b);
`ifdef VALU_SAT_EN
        logic [LANE_W-1:0] s;
        s = a + b;
`endif
        case (op)
`ifdef VALU_SAT_EN
            5'd0:    lane_alu = s < a ? '1 : s;
            5'd1:    lane_alu = a < b ? '0 : a - b;
`else
            5'd0:    lane_alu = a + b;
            5'd1:    lane_alu = a - b;
`endif
            5'd2:    lane_alu = a & b;
            5'd3:    lane_alu = a | b;
            5'd4:    lane_alu = a ^ b;
            5'd5:    lane_alu = a << b[SH-1:0];
            5'd6:    lane_alu = a >> b[SH-1:0];
            5'd7:    lane_alu = a * b;
            5'd8:    lane_alu = a < b ? a : b;
            5'd9:    lane_alu = a > b ? a : b;
            5'd10:   lane_alu = a;
            default: lane_alu = '0;
        endcase
    endfunction

`ifdef VALU_SAT_EN
    // A wrapped sum smaller than an operand means the lane overflowed.
    function automatic logic lane_sat(input logic [4:0] op, input logic [LANE_W-1:0] a, input logic [LANE_W-1:0] b);
        logic [LANE_W-1:0] s;
        s = a + b;
        lane_sat = (op == 5'd0 && s < a) || (op == 5'd1 && a < b);
    endfunction
`endif

    always_comb begin
        nxt      = '0;
        nxt.v    = 1'b1;
        nxt.rd   = in_rd;
        nxt.mask = in_mask;
        nxt.ill  = in_op > 5'd10;
        for (int i = 0; i < LANES; i++) begin
            nxt.res[i*LANE_W +: LANE_W] = in_mask[i] ? lane_alu(in_op, in_srcA[i*LANE_W +: LANE_W], in_srcB[i*LANE_W +: LANE_W])
                                                     : in_srcA[i*LANE_W +: LANE_W];
`ifdef VALU_SAT_EN
            nxt.sat = nxt.sat | (in_mask[i] & lane_sat(in_op, in_srcA[i*LANE_W +: LANE_W], in_srcB[i*LANE_W +: LANE_W]));
`endif
        end
    end

    always_comb begin
        v = '0;
        for (int k = 0; k < STAGES; k++) v[k] = st[k].v;
    end

    // A stage can load if it or any stage downstream of it has room.
    for (genvar k = 0; k < STAGES; k++) begin : g_rdy
        assign rdy[k] = out_ready | ~&v[STAGES-1:k];
    end

    assign in_ready    = rdy[0] & ~flush;
    assign acc         = in_valid & in_ready;
    assign busy        = |v;
    assign out_valid   = st[STAGES-1].v;
    assign out_result  = st[STAGES-1].res;
    assign out_rd      = st[STAGES-1].rd;
    assign out_mask    = st[STAGES-1].mask;
    assign out_illegal = st[STAGES-1].ill;
`ifdef VALU_SAT_EN
    assign sat_flag    = st[STAGES-1].sat;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < STAGES; k++) st[k] <= '0;
        end else begin
            if (acc) st[0] <= nxt;
            st[0].v <= rdy[0] ? acc : st[0].v && !flush;
            for (int k = 1; k < STAGES; k++) begin
                if (rdy[k] && st[k-1].v) st[k] <= st[k-1];
                st[k].v <= !flush && (rdy[k] ? st[k-1].v : st[k].v);
            end
        end
    end
endmodule

// File: tb/tb_vector_alu_pipe.sv
// tb_vector_alu_pipe: directed and randomized checks of vector_alu_pipe against a lane-arithmetic reference model.
module tb_vector_alu_pipe;
    localparam int LANES = 4, LANE_W = 8, STAGES = 2, TAG_W = 5;
`ifdef VALU_SAT_EN
    localparam logic [31:0] T1_RES = 32'h11FF0203;
`else
    localparam logic [31:0] T1_RES = 32'h11000203;
`endif

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic [3:0]  mask;
        logic        ill;
        logic        sat;
    } exp_t;

    logic        clk = 1'b0, reset = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid, out_illegal, busy;
    logic [4:0]  in_op = '0, in_rd = '0, out_rd;
    logic [31:0] in_srcA = '0, in_srcB = '0, out_result;
    logic [3:0]  in_mask = '0, out_mask;
`ifdef VALU_SAT_EN
    logic        sat_flag;
`endif

    int   checks = 0, errors = 0, popped = 0;
    exp_t exp_q[$];

    vector_alu_pipe #(.LANES(LANES), .LANE_W(LANE_W), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_srcA(in_srcA), .in_srcB(in_srcB), .in_mask(in_mask), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd),
        .out_mask(out_mask), .out_illegal(out_illegal),
`ifdef VALU_SAT_EN
        .sat_flag(sat_flag),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(logic [4:0] op, logic [31:0] a, logic [31:0] b, logic [3:0] m, logic [4:0] rd);
        exp_t e;
        e.rd = rd; e.mask = m; e.ill = op > 5'd10; e.sat = 1'b0; e.res = '0;
        for (int i = 0; i < 4; i++) begin
            int x, y, r;
            x = int'(a[i*8 +: 8]);
            y = int'(b[i*8 +: 8]);
            r = x;
            if (m[i]) begin
                case (op)
                    5'd0: begin
                        r = x + y;
`ifdef VALU_SAT_EN
                        if (r > 255) begin r = 255; e.sat = 1'b1; end
`endif
                    end
                    5'd1: begin
                        r = x - y;
`ifdef VALU_SAT_EN
                        if (r < 0) begin r = 0; e.sat = 1'b1; end
`endif
                    end
                    5'd2: r = x & y;
                    5'd3: r = x | y;
                    5'd4: r = x ^ y;
                    5'd5: r = x << (y % 8);
                    5'd6: r = x >> (y % 8);
                    5'd7: r = x * y;
                    5'd8: r = x < y ? x : y;
                    5'd9: r = x > y ? x : y;
                    5'd10: r = x;
                    default: r = 0;
                endcase
            end
            e.res[i*8 +: 8] = 8'(r);
        end
        return e;
    endfunction

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock: score the handshakes seen mid-cycle, then return 1ns after the next rising edge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (flush) exp_q.delete();
        else if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("spurious_out", out_valid, 0);
            else begin
                e = exp_q.pop_front();
                popped++;
                chk("sb_res", out_result, e.res);
                chk("sb_rd", out_rd, e.rd);
                chk("sb_mask", out_mask, e.mask);
                chk("sb_ill", out_illegal, e.ill);
`ifdef VALU_SAT_EN
                chk("sb_sat", sat_flag, e.sat);
`endif
            end
        end
        if (in_valid && in_ready && !flush) exp_q.push_back(model(in_op, in_srcA, in_srcB, in_mask, in_rd));
        @(posedge clk);
        #1;
    endtask

    task automatic rand_op();
        in_op = 5'($urandom_range(0, 15));
        in_srcA = $urandom;
        in_srcB = $urandom;
        in_mask = 4'($urandom);
        in_rd = 5'($urandom);
    endtask

    task automatic directed(string tag, logic [4:0] op, logic [31:0] a, logic [31:0] b, logic [3:0] m, logic [4:0] rd,
                            logic [31:0] er, logic eill);
        in_valid = 1'b1; in_op = op; in_srcA = a; in_srcB = b; in_mask = m; in_rd = rd;
        step();
        in_valid = 1'b0;
        chk({tag, "_early"}, out_valid, 0);
        step();
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_res"}, out_result, er);
        chk({tag, "_rd"}, out_rd, rd);
        chk({tag, "_ill"}, out_illegal, eill);
        step();
    endtask

    initial begin
        logic [31:0] held;
        int p0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_rd", out_rd, 0);
        chk("rst_out_mask", out_mask, 0);
        chk("rst_out_ill", out_illegal, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        reset = 1'b1;
        out_ready = 1'b1;

        directed("t1_add", 5'd0, 32'h10FF0102, 32'h01010101, 4'hF, 5'd3, T1_RES, 1'b0);

        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_op();
            in_valid = 1'b1;
            step();
        end
        chk("t2_in_ready_full", in_ready, 0);
        chk("t2_accepted", exp_q.size(), 2);
        held = out_result;
        step();
        step();
        chk("t2_stable", out_result, held);
        chk("t2_valid_held", out_valid, 1);
        chk("t2_busy", busy, 1);
        out_ready = 1'b1;
        step();
        chk("t2_no_bubble", exp_q.size(), 2);
        in_valid = 1'b0;
        repeat (3) step();
        chk("t2_drained", exp_q.size(), 0);

        p0 = popped;
        for (int i = 0; i < 20; i++) begin
            rand_op();
            in_valid = 1'b1;
            step();
            chk("t3_in_ready", in_ready, 1);
        end
        in_valid = 1'b0;
        step();
        step();
        chk("t3_count", popped - p0, 20);

        rand_op(); in_valid = 1'b1; step();
        rand_op(); step();
        in_valid = 1'b1;
        flush = 1'b1;
        #1;
        chk("t4_busy_before", busy, 1);
        chk("t4_no_accept", in_ready, 0);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("t4_busy", busy, 0);
        chk("t4_out_valid", out_valid, 0);
        directed("t4_post", 5'd4, 32'hF0F00F0F, 32'hFF00FF00, 4'hF, 5'd9, 32'h0FF0F00F, 1'b0);

        directed("t5_sll", 5'd5, 32'h01010101, 32'h00010307, 4'b0101, 5'd1, 32'h01020180, 1'b0);
        directed("t5_minu", 5'd8, 32'h05FF0010, 32'h06000011, 4'hF, 5'd2, 32'h05000010, 1'b0);
        directed("t5_mul", 5'd7, 32'h10030FFF, 32'h100511FF, 4'hF, 5'd4, 32'h000FFF01, 1'b0);
        directed("t5_ill", 5'd15, 32'hAABBCCDD, 32'h12345678, 4'b0011, 5'd5, 32'hAABB0000, 1'b1);

        for (int i = 0; i < 60; i++) begin
            rand_op();
            in_valid = 1'($urandom);
            out_ready = 1'($urandom);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();
        chk("rand_drained", exp_q.size(), 0);

        for (int i = 0; i < 4; i++) begin
            rand_op();
            in_valid = 1'b1;
            step();
        end
        chk("t6_valid_before", out_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_async_valid", out_valid, 0);
        chk("t6_async_busy", busy, 0);
        chk("t6_async_result", out_result, 0);
        chk("t6_async_rd", out_rd, 0);
        exp_q.delete();
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        chk("t6_in_ready", in_ready, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t6_no_stale", out_valid, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
